// File: rtl/user_tree_pkg.sv
// Message-tree description shared by the decoder chain: identifier paths per message,
// node payloads, and the token/state types used by the tree position tracker.
package user_tree_pkg;

    localparam int NUM_MSG_HIERARCHY = 2;
    localparam int NUM_MSGS          = 2;
    localparam int IDENTIFIER_SIZE   = 5;
    localparam int NODE_W            = 8;
    localparam int DEPTH_W           = $clog2(NUM_MSG_HIERARCHY + 1);

    localparam logic [IDENTIFIER_SIZE-1:0] TREE_ID_EMPTY = '0;

    // Slot [NUM_MSG_HIERARCHY-1] is the outermost identifier; unused slots hold 0.
    typedef logic [NUM_MSG_HIERARCHY-1:0][IDENTIFIER_SIZE-1:0] dependency;
    typedef logic [NODE_W-1:0] node_data;

    typedef enum logic [1:0] {
        OP_ENTER = 2'd0,
        OP_LEAVE = 2'd1,
        OP_CLEAR = 2'd2,
        OP_NOP   = 2'd3
    } tree_op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_RESP   = 2'd2
    } lookup_state_t;

    // Row 0: PhoneNumber (Person.phone), row 1: Person.
    localparam dependency dependencies [NUM_MSGS] = '{
        dependency'({5'd1, 5'd4}),
        dependency'({5'd1, 5'd0})
    };

    localparam node_data node_ROM [NUM_MSGS] = '{8'd1, 8'd0};

endpackage

// File: rtl/tree_node_lookup_if.sv
// Token input / lookup result bundle between the tag decoder, the tree tracker
// and the per-message handlers.
interface tree_node_lookup_if #(
    parameter int ID_W = user_tree_pkg::IDENTIFIER_SIZE,
    parameter int DW   = user_tree_pkg::DEPTH_W
);
    import user_tree_pkg::*;

    logic            in_valid;
    logic            in_ready;
    tree_op_t        in_op;
    logic [ID_W-1:0] in_id;
    logic            out_valid;
    logic            out_ready;
    logic            out_hit;
    node_data        out_node;
    logic [DW-1:0]   out_depth;
    logic            err_overflow;
    logic            err_underflow;
    logic            err_bad_id;

    modport master (
        output in_valid, in_op, in_id, out_ready,
        input  in_ready, out_valid, out_hit, out_node, out_depth,
        input  err_overflow, err_underflow, err_bad_id
    );

    modport slave (
        input  in_valid, in_op, in_id, out_ready,
        output in_ready, out_valid, out_hit, out_node, out_depth,
        output err_overflow, err_underflow, err_bad_id
    );

endinterface

// File: rtl/tree_path_stack.sv
// Identifier path and depth register; the path fills from the outermost slot down,
// so a LEAVE always clears the most recently written slot.
module tree_path_stack
    import user_tree_pkg::*;
#(
    parameter int DEPTH = NUM_MSG_HIERARCHY,
    parameter int ID_W  = IDENTIFIER_SIZE,
    localparam int DW   = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_clear,
    input  logic [ID_W-1:0]            i_id,
    output logic [DEPTH-1:0][ID_W-1:0] o_path,
    output logic [DW-1:0]              o_depth,
    output logic                       o_pushed,
    output logic                       o_overflow,
    output logic                       o_underflow
);

    localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][ID_W-1:0] r_path;
    logic [DW-1:0]              r_depth;
    logic                       w_full;
    logic                       w_empty;
    logic                       w_popped;
    logic [SW-1:0]              w_push_slot;
    logic [SW-1:0]              w_pop_slot;

    assign w_full      = (r_depth == DW'(DEPTH));
    assign w_empty     = (r_depth == '0);
    assign w_push_slot = SW'(DEPTH - 1 - int'(r_depth));
    assign w_pop_slot  = SW'(DEPTH - int'(r_depth));

    // A zero identifier would be indistinguishable from an empty slot, so it never lands.
    assign o_pushed    = i_push && !w_full && (i_id != ID_W'(TREE_ID_EMPTY));
    assign w_popped    = i_pop && !w_empty;
    assign o_overflow  = i_push && w_full;
    assign o_underflow = i_pop && w_empty;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_path  <= '0;
            r_depth <= '0;
        end else if (o_pushed) begin
            r_path[w_push_slot] <= i_id;
            r_depth             <= r_depth + 1'b1;
        end else if (w_popped) begin
            r_path[w_pop_slot] <= '0;
            r_depth            <= r_depth - 1'b1;
        end
    end

    assign o_path  = r_path;
    assign o_depth = r_depth;

endmodule

// File: rtl/tree_node_lookup.sv
// Tracks the position in the message tree from ENTER/LEAVE/CLEAR tokens and, after
// each successful ENTER, scans the dependency table to report the matching node.
module tree_node_lookup
    import user_tree_pkg::*;
#(
    parameter int DEPTH   = NUM_MSG_HIERARCHY,
    parameter int ENTRIES = NUM_MSGS,
    parameter int ID_W    = IDENTIFIER_SIZE
) (
    input logic               clk,
    input logic               rst,
    tree_node_lookup_if.slave bus
);

    localparam int KW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int DW = $clog2(DEPTH + 1);

    lookup_state_t              r_state;
    logic [KW-1:0]              r_k;
    logic                       r_out_valid;
    logic                       r_hit;
    node_data                   r_node;
    logic                       r_err_overflow;
    logic                       r_err_underflow;
    logic                       r_err_bad_id;

    logic                       w_accept;
    logic                       w_enter;
    logic                       w_leave;
    logic                       w_clear;
    logic                       w_bad_id;
    logic                       w_pushed;
    logic                       w_overflow;
    logic                       w_underflow;
    logic                       w_match;
    logic                       w_last;
    logic [DEPTH-1:0][ID_W-1:0] w_path;
    logic [DW-1:0]              w_depth;

    assign w_accept = bus.in_valid && (r_state == ST_IDLE);
    assign w_enter  = w_accept && (bus.in_op == OP_ENTER);
    assign w_leave  = w_accept && (bus.in_op == OP_LEAVE);
    assign w_clear  = w_accept && (bus.in_op == OP_CLEAR);
    assign w_bad_id = w_enter && (bus.in_id == ID_W'(TREE_ID_EMPTY));

    tree_path_stack #(
        .DEPTH (DEPTH),
        .ID_W  (ID_W)
    ) u_stack (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_enter),
        .i_pop       (w_leave),
        .i_clear     (w_clear),
        .i_id        (bus.in_id),
        .o_path      (w_path),
        .o_depth     (w_depth),
        .o_pushed    (w_pushed),
        .o_overflow  (w_overflow),
        .o_underflow (w_underflow)
    );

    // Whole-path compare: empty slots are 0 in both the path and the table rows.
    assign w_match = (w_path == dependencies[r_k]);
    assign w_last  = (r_k == KW'(ENTRIES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_k             <= '0;
            r_out_valid     <= 1'b0;
            r_hit           <= 1'b0;
            r_node          <= '0;
            r_err_overflow  <= 1'b0;
            r_err_underflow <= 1'b0;
            r_err_bad_id    <= 1'b0;
        end else begin
            if (w_clear) begin
                r_err_overflow  <= 1'b0;
                r_err_underflow <= 1'b0;
                r_err_bad_id    <= 1'b0;
            end else begin
                if (w_overflow)  r_err_overflow  <= 1'b1;
                if (w_underflow) r_err_underflow <= 1'b1;
                if (w_bad_id)    r_err_bad_id    <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_pushed) begin
                        r_state <= ST_SEARCH;
                        r_k     <= '0;
                    end
                end
                ST_SEARCH: begin
                    // Ascending scan: the lowest matching row wins.
                    if (w_match) begin
                        r_state     <= ST_RESP;
                        r_out_valid <= 1'b1;
                        r_hit       <= 1'b1;
                        r_node      <= node_ROM[r_k];
                    end else if (w_last) begin
                        r_state     <= ST_RESP;
                        r_out_valid <= 1'b1;
                        r_hit       <= 1'b0;
                        r_node      <= '0;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (bus.out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready      = (r_state == ST_IDLE);
    assign bus.out_valid     = r_out_valid;
    assign bus.out_hit       = r_hit;
    assign bus.out_node      = r_node;
    assign bus.out_depth     = w_depth;
    assign bus.err_overflow  = r_err_overflow;
    assign bus.err_underflow = r_err_underflow;
    assign bus.err_bad_id    = r_err_bad_id;

endmodule

// File: doc/tree_node_lookup.md
# tree_node_lookup

Tracks the current position in the message tree from a stream of ENTER/LEAVE/CLEAR tokens, produced by the field decoder upstream. On every ENTER it matches the resulting identifier path against the package `dependencies` table and emits the matching `node_ROM` entry. It sits directly downstream of the tag decoder and feeds `node_data` to the per-message handlers.

## Interface
- `DEPTH`, default `NUM_MSG_HIERARCHY` (2): maximum nesting depth, equal to the number of path slots.
- `ENTRIES`, default `NUM_MSGS` (2): number of rows in `dependencies` / `node_ROM`.
- `ID_W`, default `IDENTIFIER_SIZE` (5): identifier width.
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset, synchronous and active-high.
- `in_valid`, in, 1: token valid.
- `in_ready`, out, 1: token accepted on `in_valid && in_ready`.
- `in_op`, in, 2, `tree_op_t`: 0 ENTER, 1 LEAVE, 2 CLEAR, 3 reserved (treated as NOP).
- `in_id`, in, `ID_W`: identifier for ENTER; ignored otherwise.
- `out_valid`, out, 1: lookup result valid.
- `out_ready`, in, 1: result consumed on `out_valid && out_ready`.
- `out_hit`, out, 1: the path matched a row.
- `out_node`, out, `node_data`: `node_ROM[k]` on a hit, 0 on a miss.
- `out_depth`, out, `$clog2(DEPTH+1)`: current depth, always live.
- `err_overflow`, out, 1: sticky; an ENTER arrived at depth == `DEPTH`.
- `err_underflow`, out, 1: sticky; a LEAVE arrived at depth 0.
- `err_bad_id`, out, 1: sticky; an ENTER arrived with `in_id == 0`.

## Operation
- Path register `path` has type `dependency`, `DEPTH` slots of `ID_W` bits each.
  - `path[DEPTH-1]` is the outermost slot.
  - Unused slots hold 0, so identifier 0 is reserved to mean "empty".
- ENTER at depth d < `DEPTH`, with `in_id != 0`:
  - write `path[DEPTH-1-d] = in_id`, set depth = d+1;
  - go to SEARCH with k = 0.
- ENTER with an error condition (overflow or `in_id == 0`):
  - path and depth are unchanged, no result is produced;
  - set the matching sticky flag;
  - stay in IDLE.
- LEAVE at depth d > 0: clear `path[DEPTH-d]`, set depth = d-1, no result. LEAVE at depth 0 sets `err_underflow` and changes nothing else.
- CLEAR: path = 0, depth = 0, all sticky error flags cleared, no result.
- FSM states:
  - IDLE: `in_ready = 1`.
  - SEARCH: `in_ready = 0`. Each cycle compares the whole `path` with `dependencies[k]`.
    - On a match, go to RESP with hit = 1 and node = `node_ROM[k]`.
    - Else if k == `ENTRIES-1`, go to RESP with hit = 0 and node = 0.
    - Else k++.
  - RESP: `out_valid = 1`, with `out_hit` and `out_node` held stable until `out_ready`. Then go to IDLE.
- Scan order is fixed at k = 0 upward, so the first matching row wins.
- Reset values:
  - state IDLE, path 0, depth 0;
  - `out_valid`, `out_hit`, `out_node` all 0;
  - all error flags 0.
- `rst` asserted mid-SEARCH or mid-RESP discards the pending result. No `out_valid` is produced after reset.

## Timing
- `in_ready` is combinational from state (IDLE only). It does not depend on `in_valid`.
- Acceptance edge at cycle 0. A row matching at index k gives `out_valid` high from cycle k+2. A miss gives `out_valid` from cycle `ENTRIES`+1.
- The new `path` and `out_depth` are visible from cycle 1.
- When RESP is consumed at cycle t, `in_ready` is 1 at cycle t+1. There is no same-cycle turnaround.
- LEAVE, CLEAR and error ENTERs take one cycle. `in_ready` stays 1, so back-to-back tokens are accepted.
- `out_valid` never drops without `out_ready`, and the output fields never change while `out_valid` is high.

## Structure
- Add to `user_tree_pkg`:
  - `tree_op_t` enum;
  - `TREE_ID_EMPTY = 0`;
  - `DEPTH_W = $clog2(NUM_MSG_HIERARCHY+1)`.
- The lookup reads the package consts `dependencies` and `node_ROM` directly. It has no local copies.
- One sub-module, `tree_path_stack`, holds the path/depth register with push/pop/clear ports and the overflow/underflow detection. The FSM and scan counter live in the top module.

## Test plan
- After reset, ENTER 0x01 -> `path = {01,00}`; `out_valid` at cycle 3 with hit = 1, node = 0 (Person).
- Then ENTER 0x04 -> `path = {01,04}`, depth 2; `out_valid` at cycle 2 with hit = 1, node = 1 (PhoneNumber).
- With `out_ready` held low for 5 cycles -> `out_valid` and the output fields stay stable and `in_ready` stays 0. On release, `in_ready` is 1 the next cycle.
- Depth 2 then ENTER 0x07 -> `err_overflow = 1`, path unchanged, no result. Then LEAVE, LEAVE, LEAVE -> depth 0, `err_underflow = 1`. Then CLEAR -> both flags 0.
- ENTER 0x03 from root -> hit = 0, node = 0 at cycle 3. ENTER 0x00 -> `err_bad_id = 1`, depth unchanged.
- `rst` pulsed during SEARCH of ENTER 0x01 -> no `out_valid`, depth 0, `in_ready = 1` on the cycle after reset deasserts.
